// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode. Holds up to DEPTH fetch
// bundles so fetch can run ahead of a stalled decode, and decode can drain
// buffered instructions during an I-cache miss. Flush empties it in one cycle.
module if_id_queue #(
  parameter int ENTRY_W = 131,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Flush,
  input  logic               In_Valid,
  input  logic [ENTRY_W-1:0] In_Data,
  output logic               In_Ready,
  output logic               Out_Valid,
  output logic [ENTRY_W-1:0] Out_Data,
  input  logic               Out_Ready,
  output logic [CNT_W-1:0]   Count,
  output logic               Full,
  output logic               Empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][ENTRY_W-1:0] mem;
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [CNT_W-1:0]              cnt;
  logic                          push, pop;

  // Status flags come straight from the registered count, so In_Ready
  // never depends combinationally on Out_Ready.
  assign Full      = (cnt == CNT_W'(DEPTH));
  assign Empty     = (cnt == '0);
  assign Count     = cnt;
  assign In_Ready  = ~Full;
  assign Out_Valid = ~Empty;
  // A push into a full queue is refused even when a pop frees a slot.
  assign push      = In_Valid & ~Full;
  assign pop       = Out_Ready & ~Empty;
  // Head is gated to zero when empty; no bypass from In_Data.
  assign Out_Data  = Empty ? '0 : mem[rd_ptr];

  // Storage write; contents are never cleared, the count hides stale data.
  always_ff @(posedge Clk) begin
    if (!Rst && !Flush && push) mem[wr_ptr] <= In_Data;
  end

  // Pointer and occupancy update; Rst over Flush over push/pop.
  always_ff @(posedge Clk) begin
    if (Rst || Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: table of per-cycle vectors plus a
// hand-written no-bypass sequence.
module tb_if_id_queue;
  localparam int ENTRY_W = 131;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic               Clk = 1'b0;
  logic               Rst, Flush, In_Valid, Out_Ready;
  logic [ENTRY_W-1:0] In_Data;
  logic               In_Ready, Out_Valid, Full, Empty;
  logic [ENTRY_W-1:0] Out_Data;
  logic [CNT_W-1:0]   Count;

  if_id_queue #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .In_Valid(In_Valid),
    .In_Data(In_Data), .In_Ready(In_Ready), .Out_Valid(Out_Valid),
    .Out_Data(Out_Data), .Out_Ready(Out_Ready), .Count(Count),
    .Full(Full), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, flush, iv, ordy;
    logic [31:0] ir;
    int          cnt;
    logic        ov;
    logic [31:0] oir;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  // Every field of the bundle is derived from IR so the full width is checked.
  function automatic logic [ENTRY_W-1:0] mk(input logic [31:0] ir);
    logic [31:0] pc;
    pc = ir << 2;
    return {ir + 32'h100, ir[1:0], ~ir, pc, ir[0], ir};
  endfunction

  function automatic vec_t v(input logic rst, flush, iv, input logic [31:0] ir,
                             input logic ordy, input int cnt, input logic ov,
                             input logic [31:0] oir);
    vec_t t;
    t.rst = rst; t.flush = flush; t.iv = iv; t.ir = ir; t.ordy = ordy;
    t.cnt = cnt; t.ov = ov; t.oir = oir;
    return t;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [ENTRY_W-1:0] act, exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic check_state(input int idx, input int cnt, input logic ov,
                             input logic [31:0] oir);
    logic [ENTRY_W-1:0] ed;
    ed = ov ? mk(oir) : '0;
    applied++;
    chk("count",     idx, ENTRY_W'(Count),     ENTRY_W'(cnt));
    chk("out_valid", idx, ENTRY_W'(Out_Valid), ENTRY_W'(ov));
    chk("out_data",  idx, Out_Data,            ed);
    chk("full",      idx, ENTRY_W'(Full),      ENTRY_W'(cnt == DEPTH));
    chk("empty",     idx, ENTRY_W'(Empty),     ENTRY_W'(cnt == 0));
    chk("in_ready",  idx, ENTRY_W'(In_Ready),  ENTRY_W'(cnt != DEPTH));
  endtask

  initial begin
    Rst = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0; In_Data = '0;
    //            rst flush iv  ir            ordy cnt ov  oir
    vecs.push_back(v(1, 0, 0, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, 0, 0, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(0, 0, 1, 32'h1,        0, 1, 1, 32'h1));
    vecs.push_back(v(0, 0, 1, 32'h2,        0, 2, 1, 32'h1));
    vecs.push_back(v(0, 0, 1, 32'h3,        0, 3, 1, 32'h1));
    vecs.push_back(v(0, 0, 1, 32'h4,        0, 4, 1, 32'h1));
    vecs.push_back(v(0, 0, 1, 32'h5,        0, 4, 1, 32'h1)); // rejected
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 3, 1, 32'h2));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 2, 1, 32'h3));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 1, 1, 32'h4));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(v(0, 0, 1, 32'h10,       1, 1, 1, 32'h10));
    vecs.push_back(v(0, 0, 1, 32'h11,       1, 1, 1, 32'h11));
    vecs.push_back(v(0, 0, 1, 32'h12,       1, 1, 1, 32'h12));
    vecs.push_back(v(0, 0, 1, 32'h13,       1, 1, 1, 32'h13));
    vecs.push_back(v(0, 0, 1, 32'h14,       1, 1, 1, 32'h14)); // wrap
    vecs.push_back(v(0, 0, 1, 32'h15,       1, 1, 1, 32'h15));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(v(0, 0, 1, 32'h20,       0, 1, 1, 32'h20));
    vecs.push_back(v(0, 0, 1, 32'h21,       0, 2, 1, 32'h20));
    vecs.push_back(v(0, 0, 1, 32'h22,       0, 3, 1, 32'h20));
    vecs.push_back(v(0, 0, 1, 32'h23,       0, 4, 1, 32'h20));
    vecs.push_back(v(0, 0, 1, 32'h24,       1, 3, 1, 32'h21)); // push+pop at full
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 3, 1, 32'h21));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 2, 1, 32'h22));
    vecs.push_back(v(0, 1, 1, 32'h30,       1, 0, 0, 32'h0));  // flush
    vecs.push_back(v(0, 0, 1, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF));
    vecs.push_back(v(0, 0, 1, 32'h40,       0, 2, 1, 32'hDEADBEEF));
    vecs.push_back(v(0, 0, 1, 32'h41,       0, 3, 1, 32'hDEADBEEF));
    vecs.push_back(v(1, 0, 1, 32'h42,       0, 0, 0, 32'h0));  // reset mid-stream
    vecs.push_back(v(0, 0, 1, 32'h50,       0, 1, 1, 32'h50));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 0, 0, 32'h0));

    foreach (vecs[i]) begin
      @(negedge Clk);
      Rst = vecs[i].rst; Flush = vecs[i].flush; In_Valid = vecs[i].iv;
      Out_Ready = vecs[i].ordy; In_Data = mk(vecs[i].ir);
      @(posedge Clk); #1;
      check_state(i, vecs[i].cnt, vecs[i].ov, vecs[i].oir);
    end

    // Empty queue with push and pop offered together: nothing is forwarded.
    @(negedge Clk);
    Rst = 1'b0; Flush = 1'b0; In_Valid = 1'b1; Out_Ready = 1'b1;
    In_Data = mk(32'h60);
    #1 check_state(100, 0, 0, 32'h0);
    @(posedge Clk); #1;
    check_state(101, 1, 1, 32'h60);
    @(negedge Clk);
    In_Valid = 1'b0;
    @(posedge Clk); #1;
    check_state(102, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
